// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch flush, memory freeze and halt.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/branch-flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  input  logic       i_branch_taken,
  input  logic       i_mem_req,
  input  logic       i_mem_ready,
  input  logic       i_halt_req,
  input  logic       i_resume,
  output logic       o_pc_write,
  output logic       o_if_id_write,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_pipe_freeze,
  output logic       o_mem_wb_bubble,
  output logic       o_halted,
  output logic       o_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] o_stall_cycles
  , output logic [CNT_W-1:0] o_flush_count
`endif
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_next_cnt;
  logic            r_mem_timeout;
  logic            w_set_timeout;
  logic            w_mem_stall;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_load_use;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_rs1_hit   = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit   = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_load_use  = i_ex_mem_read & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      if (w_set_timeout)
        r_mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_wait_cnt;
    w_set_timeout = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_next_state = MEM_WAIT;
          w_next_cnt   = WC_W'(1);
        end else if (!w_load_use && i_halt_req) begin
          w_next_state = HALT;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ready) begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end else if (r_wait_cnt == WC_MAX) begin
          w_set_timeout = 1'b1;
          w_next_state  = HALT;
          w_next_cnt    = '0;
        end else begin
          w_next_cnt = r_wait_cnt + WC_W'(1);
        end
      end
      HALT: begin
        if (i_resume)
          w_next_state = RUN;
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_pipe_freeze   = 1'b0;
    o_mem_wb_bubble = 1'b0;
    o_halted        = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          o_pc_write      = 1'b0;
          o_if_id_write   = 1'b0;
          o_pipe_freeze   = 1'b1;
          o_mem_wb_bubble = 1'b1;
        end else if (w_load_use) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_id_ex_flush = 1'b1;
        end else if (i_halt_req) begin
          // The halting instruction itself still moves into EX.
          o_pc_write    = 1'b0;
          o_if_id_flush = 1'b1;
        end else if (i_branch_taken) begin
          o_if_id_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!i_mem_ready) begin
          o_pc_write      = 1'b0;
          o_if_id_write   = 1'b0;
          o_pipe_freeze   = 1'b1;
          o_mem_wb_bubble = 1'b1;
        end
      end
      HALT: begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_id_ex_flush = 1'b1;
        o_halted      = 1'b1;
      end
      default: begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
      end
    endcase
  end

  assign o_mem_timeout = r_mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic w_branch_flush;
  assign w_branch_flush = (r_state == RUN) & ~w_mem_stall & ~w_load_use &
                          ~i_halt_req & i_branch_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      if (!o_pc_write && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + CNT_W'(1);
      if (w_branch_flush && (o_flush_count != '1))
        o_flush_count <= o_flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT overridden to 4).
// Expected output vectors are ordered {pc, ifw, iff, ief, frz, bub, hlt, to}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] idRs1, idRs2, exRd;
  logic       usesRs1, usesRs2, exMemRead, branchTaken;
  logic       memReq, memReady, haltReq, resume;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExFlush;
  logic       pipeFreeze, memWbBubble, halted, memTimeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCycles, flushCount;
  int          expStall = 0;
  int          expFlush = 0;
`endif

  int cmpCount = 0;
  int errCount = 0;

  localparam logic [7:0] DEF   = 8'b1100_0000;
  localparam logic [7:0] LU    = 8'b0001_0000;
  localparam logic [7:0] BR    = 8'b1110_0000;
  localparam logic [7:0] ST    = 8'b0000_1100;
  localparam logic [7:0] HREQ  = 8'b0110_0000;
  localparam logic [7:0] HALTD = 8'b0001_0010;
  localparam logic [7:0] TO    = 8'b0000_0001;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_uses_rs1(usesRs1), .i_id_uses_rs2(usesRs2),
    .i_ex_rd(exRd), .i_ex_mem_read(exMemRead),
    .i_branch_taken(branchTaken), .i_mem_req(memReq), .i_mem_ready(memReady),
    .i_halt_req(haltReq), .i_resume(resume),
    .o_pc_write(pcWrite), .o_if_id_write(ifIdWrite), .o_if_id_flush(ifIdFlush),
    .o_id_ex_flush(idExFlush), .o_pipe_freeze(pipeFreeze),
    .o_mem_wb_bubble(memWbBubble), .o_halted(halted), .o_mem_timeout(memTimeout)
`ifdef PIPE_CTRL_PERF_EN
    , .o_stall_cycles(stallCycles), .o_flush_count(flushCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic br, input logic mreq, input logic mrdy,
                               input logic hreq, input logic res);
    idRs1 = rs1; idRs2 = rs2; usesRs1 = u1; usesRs2 = u2;
    exRd = rd; exMemRead = mr; branchTaken = br;
    memReq = mreq; memReady = mrdy; haltReq = hreq; resume = res;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze, memWbBubble, halted, memTimeout};
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
`ifdef PIPE_CTRL_PERF_EN
    cmpCount++;
    assert (stallCycles === 32'(expStall)) else begin
      errCount++;
      $error("[TB] FAIL %s.stall observed=%0d expected=%0d", tag, stallCycles, expStall);
    end
    cmpCount++;
    assert (flushCount === 32'(expFlush)) else begin
      errCount++;
      $error("[TB] FAIL %s.flush observed=%0d expected=%0d", tag, flushCount, expFlush);
    end
`endif
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then move to the next negedge.
  task automatic step(input string tag, input logic [7:0] exp);
    #1 checkOutput(tag, exp);
`ifdef PIPE_CTRL_PERF_EN
    if (!exp[7]) expStall++;
    if (exp[7] && exp[5]) expFlush++;
`endif
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0;
    idle();
    @(negedge clk);
    #1 checkOutput("reset", DEF);
    #1 rstN = 1'b1;
    @(negedge clk);

    step("idle_run", DEF);

    // Load-use on rs2, then on rs1, then a non-read register that matches
    applyStimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("lu_rs2", LU);
    idle();
    step("lu_after", DEF);
    applyStimulus(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("lu_rs1", LU);
    applyStimulus(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("lu_rs2_unused", DEF);
    applyStimulus(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("lu_x0", DEF);

    // Branch alone, then branch hidden behind load-use
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch", BR);
    idle();
    step("branch_after", DEF);
    applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch_lu", LU);

    // Memory stall wins over load-use; three wait cycles then ready (branch ignored)
    applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mem_stall_1", ST);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mem_stall_2", ST);
    step("mem_stall_3", ST);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("mem_ready", DEF);
    idle();
    step("mem_back_run", DEF);

    // Timeout: one RUN stall cycle plus four MEM_WAIT cycles, then HALT
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("to_wait", ST);
    step("to_halted", HALTD | TO);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("to_resume", HALTD | TO);
    idle();
    step("to_sticky", DEF | TO);

    // Halt request, park, then asynchronous reset mid-cycle
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("halt_req", HREQ | TO);
    idle();
    step("halt_1", HALTD | TO);
    #1 checkOutput("halt_2", HALTD | TO);
    #1 rstN = 1'b0;
    #1 checkOutput("halt_reset", DEF);
`ifdef PIPE_CTRL_PERF_EN
    expStall = 0;
    expFlush = 0;
`endif
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    step("post_reset", DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
